// File: rtl/inst_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package inst_loader_pkg;

   // Loader control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   // Requested word count limited to the memory depth.
   function automatic int unsigned clamp_len(input int unsigned num_words,
                                             input int unsigned depth);
      return (num_words > depth) ? depth : num_words;
   endfunction

endpackage

// File: rtl/inst_mem_loader_asm.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
// Latency: each accepted byte is visible in word_out the cycle after byte_en.
// Backpressure: none of its own; it only counts bytes the caller marks with byte_en.
//
// Ports: clk, rst_n (sync, active low), clr (restart at byte 0), byte_en/byte_in
// (accepted byte), word_out (lanes written so far), last (current byte is lane BPW-1).
module word_assembler #(
   parameter int BITS = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            byte_en,
   input  logic [7:0]      byte_in,
   output logic [BITS-1:0] word_out,
   output logic            last
);

   localparam int BPW = BITS / 8;
   localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

   logic [CW-1:0] byte_cnt;

   // Combinational so the caller can capture the final lane on the same edge.
   assign last = byte_en && (byte_cnt == CW'(BPW - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_cnt <= '0;
         word_out <= '0;
      end else if (clr) begin
         byte_cnt <= '0;
         word_out <= '0;
      end else if (byte_en) begin
         word_out[8*byte_cnt +: 8] <= byte_in;
         // Explicit wrap keeps non-power-of-two BPW correct.
         byte_cnt <= last ? '0 : byte_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-memory writer: streams bytes into BITS-wide little-endian words and
// writes them to addresses 0..len-1, holding the core in reset while loading.
// Latency: one WRITE cycle after the last byte of each word (BPW+1 cycles/word best case);
// Backpressure: in_ready is high only in RECV; stalls on in_valid are unbounded.
// Optional: define INST_LOADER_CHECKSUM_EN for an 8-bit running sum of accepted bytes.
//
// Ports: clk, rst_n (sync, active low); start + num_words begin a load from IDLE;
// in_valid/in_data/in_ready byte stream; we/waddr/wdata memory write port;
// busy, done (1-cycle pulse), cpu_rst_n (low while busy), checksum.
module inst_mem_loader
   import inst_loader_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int BITS   = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [BITS-1:0]   wdata,
   output logic              busy,
   output logic              done,
   output logic              cpu_rst_n,
   output logic [7:0]        checksum
);

   localparam int LW = ADDR_W + 1;

   loader_state_t   state, state_nxt;
   logic [LW-1:0]   len, word_cnt, word_cnt_inc, start_len;
   logic            start_acc, byte_en, asm_last;
   logic [BITS-1:0] asm_word, wdata_nxt;

   assign start_len    = LW'(clamp_len(32'(num_words), 32'(DEPTH)));
   assign start_acc    = (state == IDLE) && start;
   assign byte_en      = (state == RECV) && in_valid;
   assign word_cnt_inc = word_cnt + LW'(1);

   // Outputs are pure state decodes, so they never glitch with in_valid.
   assign in_ready  = (state == RECV);
   assign we        = (state == WRITE);
   assign done      = (state == DONE);
   assign busy      = (state != IDLE);
   assign cpu_rst_n = ~busy;

   word_assembler #(.BITS(BITS)) u_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (start_acc),
      .byte_en  (byte_en),
      .byte_in  (in_data),
      .word_out (asm_word),
      .last     (asm_last)
   );

   // The top lane is still in flight on the last-byte edge; merge it directly.
   always_comb begin
      wdata_nxt = asm_word;
      wdata_nxt[BITS-1 -: 8] = in_data;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (start_len == '0) ? DONE : RECV;
         RECV:    if (asm_last) state_nxt = WRITE;
         WRITE:   state_nxt = (word_cnt_inc == len) ? DONE : RECV;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         len      <= '0;
         word_cnt <= '0;
         waddr    <= '0;
         wdata    <= '0;
      end else begin
         state <= state_nxt;
         if (start_acc) begin
            len      <= start_len;
            word_cnt <= '0;
         end
         if (state == WRITE) word_cnt <= word_cnt_inc;
         // Register the write port as the word completes so it is valid throughout
         // WRITE and holds afterwards. word_cnt < len <= DEPTH here, so no wrap.
         if (asm_last) begin
            waddr <= word_cnt[ADDR_W-1:0];
            wdata <= wdata_nxt;
         end
      end
   end

`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0] sum_q;

   always_ff @(posedge clk) begin
      if (!rst_n)         sum_q <= '0;
      else if (start_acc) sum_q <= '0;
      else if (byte_en)   sum_q <= sum_q + in_data;
   end

   assign checksum = sum_q;
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

   localparam int DEPTH = 32;
   localparam int BITS  = 64;
   localparam int AW    = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [AW:0]     num_words = '0;
   logic            in_valid = 1'b0;
   logic [7:0]      in_data = '0;
   logic            in_ready, we, busy, done, cpu_rst_n;
   logic [AW-1:0]   waddr;
   logic [BITS-1:0] wdata;
   logic [7:0]      checksum;

   always #5 clk = ~clk;

   inst_mem_loader #(.DEPTH(DEPTH), .BITS(BITS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
      .cpu_rst_n(cpu_rst_n), .checksum(checksum)
   );

   int checks = 0;
   int errors = 0;

   // Expected write sequence (model) and the instruction store as seen by the core.
   logic [BITS-1:0] exp_data [256];
   logic [AW-1:0]   exp_addr [256];
   int              exp_total = 0;
   int              rd_idx = 0;
   logic [BITS-1:0] tb_mem [DEPTH];

   int              cyc_n = 0, wr_cnt = 0, done_cnt = 0;
   int              last_we_cyc = 0, last_done_cyc = 0;
   logic [AW-1:0]   last_waddr = '0;
   logic [BITS-1:0] last_wdata = '0;
   logic            acc = 1'b0;
   logic [7:0]      sum_model = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_ck();
`ifdef INST_LOADER_CHECKSUM_EN
      return sum_model;
`else
      return 8'h00;
`endif
   endfunction

   // Per-cycle compare against the model, sampled on the falling edge.
   task automatic monitor();
      cyc_n++;
      acc = in_valid && in_ready;
      chk("cpu_rst_n_vs_busy", {63'd0, cpu_rst_n}, {63'd0, ~busy});
      if (we) begin
         wr_cnt++;
         last_we_cyc = cyc_n;
         last_waddr  = waddr;
         last_wdata  = wdata;
         tb_mem[waddr] = wdata;
         chk("in_ready_in_write", {63'd0, in_ready}, 64'd0);
         if (rd_idx < exp_total) begin
            chk("waddr", {59'd0, waddr}, {59'd0, exp_addr[rd_idx]});
            chk("wdata", wdata, exp_data[rd_idx]);
            rd_idx++;
         end else begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=addr %0d required=no write", waddr);
         end
      end
      if (done) begin
         done_cnt++;
         last_done_cyc = cyc_n;
         chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
         chk("checksum_at_done", {56'd0, checksum}, {56'd0, exp_ck()});
      end
   endtask

   // One clock: compare on the falling edge, return 1 time unit after the rising edge.
   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic enqueue(input logic [AW-1:0] a, input logic [BITS-1:0] d);
      exp_addr[exp_total] = a;
      exp_data[exp_total] = d;
      exp_total++;
   endtask

   task automatic do_start(input int n, input bit clr_model);
      start = 1'b1;
      num_words = (AW+1)'(n);
      step();
      start = 1'b0;
      if (clr_model) sum_model = 8'h00;
   endtask

   task automatic push_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) step();
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      do begin
         step();
         t++;
      end while (!acc && t < 100);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL byte_accept_timeout actual=not accepted required=accepted byte %h", b);
      end else begin
         sum_model = sum_model + b;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int limit);
      int t;
      t = 0;
      while (done_cnt == d0 && t < limit) begin
         step();
         t++;
      end
      if (done_cnt == d0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no done required=done within %0d cycles", limit);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int d0, w0;
      logic [BITS-1:0] word;
      logic [7:0] b;

      // Reset and idle state.
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk("rst_we", {63'd0, we}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_waddr", {59'd0, waddr}, 64'd0);
      chk("rst_wdata", wdata, 64'd0);
      chk("rst_checksum", {56'd0, checksum}, 64'd0);

      // Zero-length load: straight to DONE, no writes.
      d0 = done_cnt;
      w0 = wr_cnt;
      do_start(0, 1'b1);
      chk("zero_busy", {63'd0, busy}, 64'd1);
      chk("zero_done", {63'd0, done}, 64'd1);
      step();
      chk("zero_busy_after", {63'd0, busy}, 64'd0);
      chk("zero_done_after", {63'd0, done}, 64'd0);
      chk("zero_done_count", 64'(done_cnt - d0), 64'd1);
      chk("zero_no_write", 64'(wr_cnt - w0), 64'd0);

      // Single word, in_valid held high.
      d0 = done_cnt;
      w0 = wr_cnt;
      do_start(1, 1'b1);
      enqueue(5'd0, 64'h0807060504030201);
      for (int i = 1; i <= 8; i++) push_byte(8'(i), 0);
      wait_done(d0, 20);
      chk("single_write_count", 64'(wr_cnt - w0), 64'd1);
      chk("single_waddr", {59'd0, last_waddr}, 64'd0);
      chk("single_wdata", last_wdata, 64'h0807060504030201);
      chk("single_done_after_write", 64'(last_done_cyc - last_we_cyc), 64'd1);
`ifdef INST_LOADER_CHECKSUM_EN
      chk("single_checksum", {56'd0, checksum}, 64'h24);
`else
      chk("single_checksum", {56'd0, checksum}, 64'h00);
`endif
      step();
      chk("single_released", {63'd0, cpu_rst_n}, 64'd1);

      // Full depth, request clamped from 40 to 32.
      d0 = done_cnt;
      w0 = wr_cnt;
      do_start(40, 1'b1);
      for (int w = 0; w < DEPTH; w++) begin
         b = 8'(w);
         enqueue(AW'(w), {8{b}});
      end
      for (int w = 0; w < DEPTH; w++) begin
         b = 8'(w);
         for (int k = 0; k < 8; k++) push_byte(b, 0);
      end
      wait_done(d0, 20);
      repeat (3) step();
      chk("full_write_count", 64'(wr_cnt - w0), 64'd32);
      chk("full_last_waddr", {59'd0, last_waddr}, 64'd31);
      chk("full_all_written", 64'(exp_total - rd_idx), 64'd0);
      chk("full_done_count", 64'(done_cnt - d0), 64'd1);
      for (int a = 0; a < 8; a++) begin
         b = 8'(a);
         chk("readback", tb_mem[a], {8{b}});
      end
`ifdef INST_LOADER_CHECKSUM_EN
      chk("full_checksum", {56'd0, checksum}, 64'h80);
`endif

      // Three words with random gaps and an ignored mid-load start.
      d0 = done_cnt;
      w0 = wr_cnt;
      do_start(3, 1'b1);
      word = '0;
      for (int i = 0; i < 24; i++) begin
         word[8*(i%8) +: 8] = 8'h10 + 8'(i);
         if (i % 8 == 7) enqueue(AW'(i / 8), word);
      end
      for (int i = 0; i < 24; i++) begin
         push_byte(8'h10 + 8'(i), int'($urandom_range(0, 3)));
         if (i == 10) do_start(1, 1'b0);
      end
      wait_done(d0, 20);
      repeat (2) step();
      chk("bp_write_count", 64'(wr_cnt - w0), 64'd3);
      chk("bp_done_count", 64'(done_cnt - d0), 64'd1);
      chk("bp_all_written", 64'(exp_total - rd_idx), 64'd0);

      // Reset after byte 5 of word 2: words 0 and 1 only.
      w0 = wr_cnt;
      do_start(3, 1'b1);
      for (int w = 0; w < 2; w++) begin
         b = 8'h40 + 8'(w);
         enqueue(AW'(w), {8{b}});
      end
      for (int w = 0; w < 2; w++) begin
         b = 8'h40 + 8'(w);
         for (int k = 0; k < 8; k++) push_byte(b, 0);
      end
      for (int k = 0; k < 6; k++) push_byte(8'h77, 0);
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();
      chk("midrst_write_count", 64'(wr_cnt - w0), 64'd2);
      chk("midrst_all_written", 64'(exp_total - rd_idx), 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_waddr", {59'd0, waddr}, 64'd0);
      chk("midrst_checksum", {56'd0, checksum}, 64'd0);
      chk("midrst_mem1_kept", tb_mem[1], 64'h4141414141414141);

      d0 = done_cnt;
      w0 = wr_cnt;
      do_start(1, 1'b1);
      enqueue(5'd0, 64'ha7a6a5a4a3a2a1a0);
      for (int k = 0; k < 8; k++) push_byte(8'ha0 + 8'(k), 0);
      wait_done(d0, 20);
      repeat (2) step();
      chk("post_rst_write_count", 64'(wr_cnt - w0), 64'd1);
      chk("post_rst_waddr", {59'd0, last_waddr}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
